// File: rtl/halt_dump_ctrl_pkg.sv
// Shared definitions for the halt-and-dump controller: state encoding,
// register-file geometry, halt opcode and default timing parameters.
package halt_dump_ctrl_pkg;

  localparam int unsigned NUM_REGS           = 32;
  localparam int unsigned RF_ADDR_W          = 5;
  localparam logic [31:0] HALT_INSTR         = 32'h0000_0000;
  localparam int unsigned DEF_DRAIN_CYCLES   = 5;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_DUMP    = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // A fetched word only counts as a halt when the fetch is actually valid.
  function automatic logic is_halt(input logic valid, input logic [31:0] instr);
    return valid && (instr == HALT_INSTR);
  endfunction

endpackage

// File: rtl/halt_dump_ctrl_cycle_counter.sv
// Free-running program cycle counter with synchronous clear and count enable.
module halt_dump_ctrl_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority over enable; the count never wraps in the supported range.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/halt_dump_ctrl.sv
// Watches the fetch stream for the halt opcode, freezes and drains the core,
// then streams all 32 architectural registers out over a valid/ready port.
module halt_dump_ctrl
  import halt_dump_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ip_instr_from_imem,
  input  logic                 ip_instr_valid,
  output logic                 op_proc_stall,
  output logic [RF_ADDR_W-1:0] op_rf_rd_addr,
  input  logic [31:0]          ip_rf_rd_data,
  output logic                 op_dump_valid,
  input  logic                 ip_dump_ready,
  output logic [RF_ADDR_W-1:0] op_dump_idx,
  output logic [31:0]          op_dump_data,
  output logic [31:0]          op_cycle_count,
  output logic                 op_done,
  output logic                 op_timeout
);

  localparam logic [31:0]          TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]          DRAIN_LAST   = 32'(DRAIN_CYCLES - 1);
  localparam logic [RF_ADDR_W-1:0] LAST_IDX     = RF_ADDR_W'(NUM_REGS - 1);

  state_e                 state_r;
  logic [31:0]            drain_r;
  logic [RF_ADDR_W-1:0]   idx_r;
  logic                   stall_r;
  logic                   valid_r;
  logic                   done_r;
  logic                   timeout_r;

  logic [31:0]            cnt_s;
  logic                   halt_s;
  logic                   at_limit_s;
  logic                   cnt_en_s;
  logic                   xfer_s;

  assign halt_s     = (state_r == ST_RUN) && is_halt(ip_instr_valid, ip_instr_from_imem);
  assign at_limit_s = (cnt_s == TIMEOUT_LAST);
  // The last budget cycle is not counted, so a timed-out run reports TIMEOUT_CYCLES-1.
  assign cnt_en_s   = (state_r == ST_RUN) && !halt_s && !at_limit_s;
  assign xfer_s     = valid_r && ip_dump_ready;

  halt_dump_ctrl_cycle_counter #(
    .W (32)
  ) u_cycle_counter (
    .clk   (clk),
    .clr   (!rst),
    .en    (cnt_en_s),
    .count (cnt_s)
  );

  // Run/drain/dump sequencer; all handshake and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      drain_r   <= 32'd0;
      idx_r     <= '0;
      stall_r   <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_s) begin
            stall_r <= 1'b1;
            idx_r   <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_r <= ST_DUMP;
              valid_r <= 1'b1;
            end else begin
              state_r <= ST_DRAIN;
              drain_r <= DRAIN_LAST;
            end
          end else if (at_limit_s) begin
            state_r   <= ST_TIMEOUT;
            stall_r   <= 1'b1;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_r == 32'd0) begin
            state_r <= ST_DUMP;
            valid_r <= 1'b1;
            idx_r   <= '0;
          end else begin
            drain_r <= drain_r - 32'd1;
          end
        end
        ST_DUMP: begin
          if (xfer_s) begin
            if (idx_r == LAST_IDX) begin
              state_r <= ST_DONE;
              valid_r <= 1'b0;
              idx_r   <= '0;
              done_r  <= 1'b1;
            end else begin
              idx_r <= idx_r + RF_ADDR_W'(1);
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          state_r <= state_r;
        end
        default: begin
          state_r   <= ST_RUN;
          drain_r   <= 32'd0;
          idx_r     <= '0;
          stall_r   <= 1'b0;
          valid_r   <= 1'b0;
          done_r    <= 1'b0;
          timeout_r <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rst keeps every output quiet for the whole reset window, not just after the first edge.
  assign op_proc_stall  = rst && stall_r;
  assign op_dump_valid  = rst && valid_r;
  assign op_done        = rst && done_r;
  assign op_timeout     = rst && timeout_r;
  assign op_rf_rd_addr  = rst ? idx_r : '0;
  assign op_dump_idx    = rst ? idx_r : '0;
  assign op_dump_data   = (rst && valid_r) ? ip_rf_rd_data : 32'h0000_0000;
  assign op_cycle_count = rst ? cnt_s : 32'd0;

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Randomized bench for halt_dump_ctrl: a per-run model predicts cycle count,
// drain latency and the exact 32-beat register dump sequence.
module tb_halt_dump_ctrl;

  localparam int D  = 5;
  localparam int T  = 100;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        instr_valid = 1'b0;
  logic        proc_stall;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [31:0] cycle_count;
  logic        done;
  logic        timeout;

  logic [31:0] mem [NR];
  int checks = 0;
  int errors = 0;

  assign rf_rd_data = mem[rf_rd_addr];

  always #5 clk = ~clk;

  halt_dump_ctrl #(
    .DRAIN_CYCLES   (D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ip_instr_from_imem (instr),
    .ip_instr_valid     (instr_valid),
    .op_proc_stall      (proc_stall),
    .op_rf_rd_addr      (rf_rd_addr),
    .ip_rf_rd_data      (rf_rd_data),
    .op_dump_valid      (dump_valid),
    .ip_dump_ready      (dump_ready),
    .op_dump_idx        (dump_idx),
    .op_dump_data       (dump_data),
    .op_cycle_count     (cycle_count),
    .op_done            (done),
    .op_timeout         (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] v;
    v = $urandom;
    if (v == 32'h0) v = 32'hdead_beef;
    return v;
  endfunction

  // Hold reset for n cycles while presenting a halt word that must be ignored.
  task automatic apply_reset(input int n);
    rst = 1'b0;
    instr_valid = 1'b1;
    instr = 32'h0;
    dump_ready = 1'($urandom % 2);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_flags", {28'h0, proc_stall, dump_valid, done, timeout}, 32'h0);
      check("rst_idx", {22'h0, dump_idx, rf_rd_addr}, 32'h0);
      check("rst_data", dump_data, 32'h0);
      check("rst_cnt", cycle_count, 32'h0);
    end
    rst = 1'b1;
    instr_valid = 1'b0;
    dump_ready = 1'b0;
  endtask

  // halt_at < 0 means never halt; abort_beat >= 0 pulls reset when that beat is presented.
  task automatic do_run(input int halt_at, input int ready_mode, input bit all_valid, input int abort_beat);
    int h;
    int exp_idx;
    int cyc;
    bit halted;
    halted = 1'b0;
    h = 0;
    for (int j = 0; j < T; j++) begin
      if (j == halt_at) begin
        instr_valid = 1'b1;
        instr = 32'h0;
      end else begin
        instr_valid = all_valid ? 1'b1 : 1'($urandom % 4 != 0);
        instr = (!instr_valid && ($urandom % 3 == 0)) ? 32'h0 : rnd_instr();
      end
      @(negedge clk);
      if (j == halt_at) begin
        halted = 1'b1;
        h = j;
        check("halt_cnt", cycle_count, 32'(j));
        check("halt_stall", {31'h0, proc_stall}, 32'h1);
        break;
      end else if (j == T - 1) begin
        check("to_cnt", cycle_count, 32'(T - 1));
        check("to_flags", {28'h0, proc_stall, done, timeout, dump_valid}, 32'he);
        break;
      end else begin
        check("run_cnt", cycle_count, 32'(j + 1));
        check("run_stall", {31'h0, proc_stall}, 32'h0);
      end
    end
    if (!halted) begin
      for (int k = 0; k < 4; k++) begin
        instr_valid = 1'($urandom % 2);
        instr = ($urandom % 2 == 0) ? 32'h0 : rnd_instr();
        dump_ready = 1'b1;
        @(negedge clk);
        check("to_hold", {28'h0, proc_stall, done, timeout, dump_valid}, 32'he);
        check("to_hold_cnt", cycle_count, 32'(T - 1));
        check("to_hold_idx", {22'h0, dump_idx, rf_rd_addr}, 32'h0);
      end
      return;
    end
    instr_valid = 1'b0;
    instr = rnd_instr();
    for (int d = 0; d < D; d++) begin
      dump_ready = 1'($urandom % 2);
      check("drain_valid", {31'h0, dump_valid}, 32'h0);
      check("drain_stall", {31'h0, proc_stall}, 32'h1);
      @(negedge clk);
    end
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < NR && cyc < 400) begin
      check("beat_valid", {31'h0, dump_valid}, 32'h1);
      check("beat_idx", {22'h0, dump_idx, rf_rd_addr}, {22'h0, 5'(exp_idx), 5'(exp_idx)});
      check("beat_data", dump_data, mem[exp_idx]);
      check("beat_cnt", cycle_count, 32'(h));
      if (exp_idx == abort_beat) begin
        rst = 1'b0;
        @(negedge clk);
        check("abort_quiet", {20'h0, proc_stall, dump_valid, done, timeout, 3'h0, dump_idx}, 32'h0);
        return;
      end
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = 1'($urandom % 2);
        default: dump_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      @(negedge clk);
      if (dump_ready) exp_idx++;
      cyc++;
    end
    if (exp_idx < NR) check("dump_bound", 32'(exp_idx), 32'(NR));
    for (int k = 0; k < 3; k++) begin
      check("done_flags", {28'h0, proc_stall, done, timeout, dump_valid}, 32'hc);
      check("done_idx", {22'h0, dump_idx, rf_rd_addr}, 32'h0);
      check("done_data", dump_data, 32'h0);
      check("done_cnt", cycle_count, 32'(h));
      dump_ready = 1'b1;
      instr_valid = 1'b1;
      instr = 32'h0;
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mem[i] = 32'(i) * 32'h0000_0101;
    apply_reset(6);
    do_run(3, 0, 1'b1, -1);
    apply_reset(3);
    do_run(int'($urandom_range(0, 20)), 2, 1'b0, -1);
    apply_reset(2);
    do_run(-1, 0, 1'b0, -1);
    for (int i = 0; i < NR; i++) mem[i] = $urandom;
    apply_reset(2);
    do_run(T - 1, 1, 1'b0, -1);
    apply_reset(2);
    do_run(int'($urandom_range(5, 30)), 0, 1'b0, 10);
    apply_reset(4);
    do_run(int'($urandom_range(0, 40)), 1, 1'b0, -1);
    apply_reset(1);
    do_run(0, 1, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
